multicycle_alu_apx: RTL and testbench
=====================================

// Module: multicycle_alu_apx
// PURPOSE
//   Parametrised, multi-cycle successor of the phoeniX approximate ALU. It executes the RV32I ALU set:
//   OP, OP_IMM, JAL, JALR and AUIPC.
//   Add-class operations run on a segmented adder, SEG_WIDTH bits per cycle, with accuracy-controlled carry cutting.
//   All other operations take one cycle.
//   Sits in the execute stage and talks to the pipeline controller through a start/busy/valid handshake.
// PARAMETERS
//   XLEN            32  datapath width; must be a multiple of SEG_WIDTH; XLEN >= 8
//   SEG_WIDTH        8  adder bits resolved per cycle; NSEG = XLEN/SEG_WIDTH
//   APX_ACC_CONTROL  0  1: accuracy_level cuts inter-segment carries on ADD/ADDI/SUB; 0: always exact
// PORTS
//   clk             in   1     core clock, rising edge
//   reset           in   1     synchronous, active-low
//   start           in   1     request; sampled only in IDLE
//   opcode          in   7     RV opcode
//   funct3          in   3     RV funct3
//   funct7          in   7     RV funct7
//   accuracy_level  in   8     number of low segment boundaries with carry cut (from CSR)
//   PC              in   XLEN  program counter
//   rs1             in   XLEN  register source 1
//   rs2             in   XLEN  register source 2
//   immediate       in   XLEN  sign-extended immediate
//   busy            out  1     state != IDLE
//   alu_valid       out  1     one-cycle pulse: alu_output/alu_illegal are valid
//   alu_illegal     out  1     unsupported encoding; qualified by alu_valid
//   alu_output      out  XLEN  result; held until the next result
// BEHAVIOUR
//   Reset (reset==0 at a clk edge):
//     - state=IDLE; busy=0, alu_valid=0, alu_illegal=0, alu_output=0; segment counter=0.
//     - Reset aborts any operation in flight; no valid pulse follows.
//   Operand select (captured at start, together with op decode and accuracy_level):
//     - OP: rs1, rs2.  OP_IMM: rs1, imm.  JAL/JALR: PC, XLEN'd4.  AUIPC: PC, imm.
//     - Inputs may change after the start cycle without effect.
//   FSM:
//     - IDLE --start, add-class--> ADD (cnt=0).
//     - IDLE --start, other--> DONE (result registered).
//     - ADD: computes segment cnt each cycle; cnt==NSEG-1 --> DONE.
//     - DONE: alu_valid=1 for one cycle --> IDLE.
//     - start while busy is ignored; it is neither queued nor errored.
//   Latency (start sampled at edge 0):
//     - Single-cycle ops: alu_valid at cycle 1.
//     - Add-class: ADD occupies cycles 1..NSEG, alu_valid at cycle NSEG+1.
//     - Accepted throughput: one op per 2 cycles (single) or per NSEG+2 cycles (add).
//   Add-class: ADD, ADDI, SUB, JAL, JALR(funct3=000), AUIPC.
//     - SUB = op1 + ~op2 with carry-in 1 into segment 0.
//     - The carry register propagates between segments.
//     - Carry from segment i into i+1 is forced to 0 when APX_ACC_CONTROL==1, the op is ADD/ADDI/SUB, and i < accuracy_level.
//     - accuracy_level >= NSEG-1 cuts all boundaries; 0 gives an exact result.
//     - JAL/JALR/AUIPC are always exact.
//     - The final carry-out is discarded (mod 2^XLEN).
//   Single-cycle ops:
//     - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. XOR/OR/AND and immediate forms.
//     - Shifts SLL/SRL/SRA(+I): amount = op2[$clog2(XLEN)-1:0]; SRA/SRAI are true arithmetic.
//   Illegal encodings: result 0 and alu_illegal=1 in DONE. These are
//     - OP with funct7 not in {0000000, 0100000};
//     - 0100000 with funct3 not in {000, 101};
//     - OP_IMM shifts with a bad funct7;
//     - JALR funct3 != 000;
//     - other opcodes.
//   alu_illegal clears on the next accepted start.
// TESTING (XLEN=32, SEG_WIDTH=8, NSEG=4)
//   1. ADD rs1=0x000000FF rs2=1, APX=0
//      -> alu_output=0x00000100; busy cycles 1..5; alu_valid at cycle 5 only.
//   2. APX=1, accuracy_level=1: ADD 0x000000FF+1 -> 0x00000000; JAL PC=0x000000FC -> 0x00000100 (exact).
//   3. SUB rs1=5 rs2=7 -> 0xFFFFFFFE. SLT(0xFFFFFFFE,1) -> 1. SLTU -> 0. Each single-cycle op: alu_valid at cycle 1.
//   4. SRAI rs1=0x80000000 imm=4 -> 0xF8000000. SRA with rs2=0xFFFFFF24 uses only amount 4 -> same result.
//   5. start held high during ADD -> exactly one valid pulse.
//      Reset at cycle 2 of ADD -> busy=0, output=0, no valid pulse.
//   6. OP funct7=0000001 funct3=000 -> alu_valid and alu_illegal both 1 at cycle 1, alu_output=0.

Source files
------------

// File: rtl/multicycle_alu_apx_if.sv
// Execute-stage ALU request/response bundle between the pipeline controller
// (master) and the multi-cycle approximate ALU (slave).
interface multicycle_alu_apx_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [7:0]      accuracy_level;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] immediate;
  logic            busy;
  logic            alu_valid;
  logic            alu_illegal;
  logic [XLEN-1:0] alu_output;

  modport master (
    output start, opcode, funct3, funct7, accuracy_level, PC, rs1, rs2, immediate,
    input  busy, alu_valid, alu_illegal, alu_output
  );

  modport slave (
    input  start, opcode, funct3, funct7, accuracy_level, PC, rs1, rs2, immediate,
    output busy, alu_valid, alu_illegal, alu_output
  );
endinterface

// File: rtl/multicycle_alu_apx.sv
// Multi-cycle approximate RV32I ALU. Add-class operations resolve SEG_WIDTH
// bits per cycle on a segmented adder whose inter-segment carries can be cut
// by accuracy_level; every other operation completes in a single cycle.
module multicycle_alu_apx #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned SEG_WIDTH       = 8,
  parameter int unsigned APX_ACC_CONTROL = 0
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_alu_apx_if.slave alu
);

  localparam int unsigned NSEG  = XLEN / SEG_WIDTH;
  localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned SHW   = $clog2(XLEN);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [XLEN-1:0]  sum_q, sum_d;
  logic [XLEN-1:0]  out_q, out_d;
  logic             carry_q, carry_d;
  logic             cut_en_q, cut_en_d;
  logic [7:0]       acc_q, acc_d;
  logic             illegal_q, illegal_d;

  // Decode results for the request currently on the bus
  logic [XLEN-1:0]  op1, op2, single_res;
  logic [SHW-1:0]   shamt;
  logic             dec_add, dec_sub, dec_cut, dec_illegal;

  // Segment adder signals
  logic [SEG_WIDTH:0]   seg_sum;
  logic [XLEN-1:0]      sum_next;
  int unsigned          seg_idx;

  // Opcode decode, operand select and single-cycle result for the bus request
  always_comb begin
    op1         = alu.rs1;
    op2         = alu.rs2;
    dec_add     = 1'b0;
    dec_sub     = 1'b0;
    dec_cut     = 1'b0;
    dec_illegal = 1'b0;
    case (alu.opcode)
      OPC_OP: begin
        if (alu.funct7 == 7'b0000000) begin
          if (alu.funct3 == 3'b000) begin
            dec_add = 1'b1;
            dec_cut = 1'b1;
          end
        end else if (alu.funct7 == 7'b0100000) begin
          if (alu.funct3 == 3'b000) begin
            dec_add = 1'b1;
            dec_sub = 1'b1;
            dec_cut = 1'b1;
          end else if (alu.funct3 != 3'b101) begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        op2 = alu.immediate;
        if (alu.funct3 == 3'b000) begin
          dec_add = 1'b1;
          dec_cut = 1'b1;
        end else if (alu.funct3 == 3'b001 && alu.funct7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end else if (alu.funct3 == 3'b101 && alu.funct7 != 7'b0000000 &&
                     alu.funct7 != 7'b0100000) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        op1     = alu.PC;
        op2     = XLEN'(4);
        dec_add = 1'b1;
      end
      OPC_JALR: begin
        op1 = alu.PC;
        op2 = XLEN'(4);
        if (alu.funct3 == 3'b000) dec_add = 1'b1;
        else                      dec_illegal = 1'b1;
      end
      OPC_AUIPC: begin
        op1     = alu.PC;
        op2     = alu.immediate;
        dec_add = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase

    shamt = op2[SHW-1:0];
    case (alu.funct3)
      3'b001:  single_res = op1 << shamt;
      3'b010:  single_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b011:  single_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      3'b100:  single_res = op1 ^ op2;
      3'b101:  single_res = alu.funct7[5] ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
      3'b110:  single_res = op1 | op2;
      3'b111:  single_res = op1 & op2;
      default: single_res = '0;
    endcase
  end

  // Segmented adder step for the segment selected by cnt_q
  always_comb begin
    seg_idx  = 32'(cnt_q) * SEG_WIDTH;
    seg_sum  = {1'b0, op_a_q[seg_idx +: SEG_WIDTH]} + {1'b0, op_b_q[seg_idx +: SEG_WIDTH]}
             + {{SEG_WIDTH{1'b0}}, carry_q};
    sum_next = sum_q;
    sum_next[seg_idx +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    out_d     = out_q;
    carry_d   = carry_q;
    cut_en_d  = cut_en_q;
    acc_d     = acc_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (alu.start) begin
          illegal_d = dec_illegal;
          acc_d     = alu.accuracy_level;
          op_a_d    = op1;
          // Subtraction folds into the adder as op1 + ~op2 + 1
          op_b_d    = dec_sub ? ~op2 : op2;
          carry_d   = dec_sub;
          cut_en_d  = (APX_ACC_CONTROL == 1) && dec_cut;
          cnt_d     = '0;
          sum_d     = '0;
          if (dec_add && !dec_illegal) begin
            state_d = S_ADD;
          end else begin
            out_d   = dec_illegal ? '0 : single_res;
            state_d = S_DONE;
          end
        end
      end
      S_ADD: begin
        sum_d   = sum_next;
        carry_d = (cut_en_q && (32'(cnt_q) < 32'(acc_q))) ? 1'b0 : seg_sum[SEG_WIDTH];
        if (cnt_q == CNT_W'(NSEG - 1)) begin
          out_d   = sum_next;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      cut_en_q  <= 1'b0;
      acc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sum_q     <= sum_d;
      out_q     <= out_d;
      carry_q   <= carry_d;
      cut_en_q  <= cut_en_d;
      acc_q     <= acc_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu.busy        = (state_q != S_IDLE);
  assign alu.alu_valid   = (state_q == S_DONE);
  assign alu.alu_illegal = illegal_q;
  assign alu.alu_output  = out_q;

endmodule

// File: tb/tb_multicycle_alu_apx.sv
// Scoreboard bench for multicycle_alu_apx: one exact instance and one with
// approximate carry cutting, both driven with directed vectors.
module tb_multicycle_alu_apx;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] F7A    = 7'b0000000;
  localparam logic [6:0] F7B    = 7'b0100000;
  localparam int L_ADD = 5;
  localparam int L_ONE = 1;

  typedef struct {
    logic [31:0] out;
    logic        ill;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  multicycle_alu_apx_if #(.XLEN(32)) bus0 ();
  multicycle_alu_apx_if #(.XLEN(32)) bus1 ();

  multicycle_alu_apx #(.XLEN(32), .SEG_WIDTH(8), .APX_ACC_CONTROL(0)) dut0 (
    .clk(clk), .reset(reset), .alu(bus0.slave));
  multicycle_alu_apx #(.XLEN(32), .SEG_WIDTH(8), .APX_ACC_CONTROL(1)) dut1 (
    .clk(clk), .reset(reset), .alu(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [7:0] acc, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    if (d == 0) begin
      bus0.start = st; bus0.opcode = opc; bus0.funct3 = f3; bus0.funct7 = f7;
      bus0.accuracy_level = acc; bus0.PC = pc; bus0.rs1 = a; bus0.rs2 = b; bus0.immediate = imm;
    end else begin
      bus1.start = st; bus1.opcode = opc; bus1.funct3 = f3; bus1.funct7 = f7;
      bus1.accuracy_level = acc; bus1.PC = pc; bus1.rs1 = a; bus1.rs2 = b; bus1.immediate = imm;
    end
  endtask

  // Issue one request, push its expected response, scramble the inputs after
  // the accepting edge, and wait until the unit is idle again.
  task automatic issue(input int d, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [7:0] acc, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] exp,
                       input logic ill, input int lat, input int hold, input bit chk_busy);
    exp_t e;
    @(negedge clk);
    drive(d, 1'b1, opc, f3, f7, acc, pc, a, b, imm);
    e.out = exp; e.ill = ill; e.cyc = cyc + lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      drive(d, (k <= hold), ~opc, ~f3, ~f7, ~acc, ~pc, ~a, ~b, ~imm);
      @(negedge clk);
      if (chk_busy)
        check($sformatf("busy_c%0d", k), 32'((d == 0) ? bus0.busy : bus1.busy), 32'(k <= lat));
    end
  endtask

  // Response monitor for the exact instance
  always @(negedge clk) begin
    exp_t e;
    if (bus0.alu_valid === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut0_unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check("dut0_output", bus0.alu_output, e.out);
        check("dut0_illegal", 32'(bus0.alu_illegal), 32'(e.ill));
        check("dut0_valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Response monitor for the approximate instance
  always @(negedge clk) begin
    exp_t e;
    if (bus1.alu_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        check("dut1_output", bus1.alu_output, e.out);
        check("dut1_illegal", 32'(bus1.alu_illegal), 32'(e.ill));
        check("dut1_valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", 32'(bus0.busy), 32'd0);
    check("rst_valid0", 32'(bus0.alu_valid), 32'd0);
    check("rst_illegal0", 32'(bus0.alu_illegal), 32'd0);
    check("rst_output0", bus0.alu_output, 32'h0);
    check("rst_busy1", 32'(bus1.busy), 32'd0);
    check("rst_output1", bus1.alu_output, 32'h0);
    reset = 1'b1;

    // Exact instance
    issue(0, OP,     3'b000, F7A, 8'd0, 0, 32'h000000FF, 32'h1, 0, 32'h00000100, 0, L_ADD, 0, 1);
    issue(0, OP,     3'b000, F7A, 8'd1, 0, 32'h000000FF, 32'h1, 0, 32'h00000100, 0, L_ADD, 0, 0);
    issue(0, OP,     3'b000, F7B, 8'd0, 0, 32'h5, 32'h7, 0, 32'hFFFFFFFE, 0, L_ADD, 0, 0);
    issue(0, OP,     3'b010, F7A, 8'd0, 0, 32'hFFFFFFFE, 32'h1, 0, 32'h1, 0, L_ONE, 0, 1);
    issue(0, OP,     3'b011, F7A, 8'd0, 0, 32'hFFFFFFFE, 32'h1, 0, 32'h0, 0, L_ONE, 0, 0);
    issue(0, OP_IMM, 3'b101, F7B, 8'd0, 0, 32'h80000000, 0, 32'h00000404, 32'hF8000000, 0, L_ONE, 0, 0);
    issue(0, OP,     3'b101, F7B, 8'd0, 0, 32'h80000000, 32'hFFFFFF24, 0, 32'hF8000000, 0, L_ONE, 0, 0);
    issue(0, OP,     3'b101, F7A, 8'd0, 0, 32'h80000000, 32'h4, 0, 32'h08000000, 0, L_ONE, 0, 0);
    issue(0, OP_IMM, 3'b001, F7A, 8'd0, 0, 32'h1, 0, 32'h1F, 32'h80000000, 0, L_ONE, 0, 0);
    issue(0, OP,     3'b100, F7A, 8'd0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, L_ONE, 0, 0);
    issue(0, OP,     3'b110, F7A, 8'd0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, L_ONE, 0, 0);
    issue(0, OP_IMM, 3'b111, F7A, 8'd0, 0, 32'hF0F0F0F0, 0, 32'hFF00FF00, 32'hF000F000, 0, L_ONE, 0, 0);
    issue(0, OP_IMM, 3'b010, F7A, 8'd0, 0, 32'h5, 0, 32'hFFFFFFFF, 32'h0, 0, L_ONE, 0, 0);
    issue(0, OP_IMM, 3'b011, F7A, 8'd0, 0, 32'h5, 0, 32'hFFFFFFFF, 32'h1, 0, L_ONE, 0, 0);
    issue(0, OP,     3'b000, 7'b0000001, 8'd0, 0, 32'h3, 32'h4, 0, 32'h0, 1, L_ONE, 0, 1);
    issue(0, JALR,   3'b001, F7A, 8'd0, 32'h100, 0, 0, 0, 32'h0, 1, L_ONE, 0, 0);
    issue(0, 7'b0000000, 3'b000, F7A, 8'd0, 0, 32'h1, 32'h1, 0, 32'h0, 1, L_ONE, 0, 0);
    issue(0, OP,     3'b001, F7B, 8'd0, 0, 32'h1, 32'h1, 0, 32'h0, 1, L_ONE, 0, 0);
    issue(0, OP_IMM, 3'b001, 7'b0000001, 8'd0, 0, 32'h1, 0, 32'h21, 32'h0, 1, L_ONE, 0, 0);
    issue(0, AUIPC,  3'b000, F7A, 8'd0, 32'h00001000, 0, 0, 32'h12345000, 32'h12346000, 0, L_ADD, 0, 0);
    issue(0, JALR,   3'b000, F7A, 8'd0, 32'hFFFFFFFC, 0, 0, 0, 32'h0, 0, L_ADD, 0, 0);
    // start held through the whole operation: only one response
    issue(0, OP,     3'b000, F7A, 8'd0, 0, 32'h01020304, 32'h10203040, 0, 32'h11223344, 0, L_ADD, 5, 1);

    // Reset in the middle of an add aborts it with no response
    @(negedge clk);
    drive(0, 1'b1, OP, 3'b000, F7A, 8'd0, 0, 32'h11, 32'h22, 0);
    @(posedge clk); #1 bus0.start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(bus0.busy), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus0.busy), 32'd0);
    check("abort_output", bus0.alu_output, 32'h0);
    check("abort_valid", 32'(bus0.alu_valid), 32'd0);
    repeat (8) @(posedge clk);

    // Approximate instance
    issue(1, OP,     3'b000, F7A, 8'd1, 0, 32'h000000FF, 32'h1, 0, 32'h00000000, 0, L_ADD, 0, 0);
    issue(1, JAL,    3'b000, F7A, 8'd1, 32'h000000FC, 0, 0, 0, 32'h00000100, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7A, 8'd0, 0, 32'h000000FF, 32'h1, 0, 32'h00000100, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7A, 8'd0, 0, 32'hFFFFFFFF, 32'h01010101, 0, 32'h01010100, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7A, 8'd1, 0, 32'hFFFFFFFF, 32'h01010101, 0, 32'h01010000, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7A, 8'd2, 0, 32'hFFFFFFFF, 32'h01010101, 0, 32'h01000000, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7A, 8'd3, 0, 32'hFFFFFFFF, 32'h01010101, 0, 32'h00000000, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7A, 8'd200, 0, 32'hFFFFFFFF, 32'h01010101, 0, 32'h00000000, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7B, 8'd2, 0, 32'h00000100, 32'h1, 0, 32'hFFFF00FF, 0, L_ADD, 0, 0);
    issue(1, OP,     3'b000, F7B, 8'd0, 0, 32'h00000100, 32'h1, 0, 32'h000000FF, 0, L_ADD, 0, 0);
    issue(1, OP_IMM, 3'b000, F7A, 8'd1, 0, 32'h000000FF, 0, 32'h1, 32'h00000000, 0, L_ADD, 0, 0);
    issue(1, AUIPC,  3'b000, F7A, 8'd3, 32'h000000FF, 0, 0, 32'h1, 32'h00000100, 0, L_ADD, 0, 0);
    issue(1, JALR,   3'b000, F7A, 8'd3, 32'h000000FC, 0, 0, 0, 32'h00000100, 0, L_ADD, 0, 0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("dut0_pending_responses", 32'(q0.size()), 32'd0);
    check("dut1_pending_responses", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
